hsm_timer: RTL and testbench



---
 rtl/hsm_timer.sv | 111 +++++++++++
 tb/tb_hsm_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hsm_timer.sv
// Memory-mapped countdown timer: ID/version words, prescaler, reloadable
// 32-bit count with start/stop control and a sticky expiry flag.
module hsm_timer #(
  parameter logic [31:0] NAME0   = 32'h68736d5f,
  parameter logic [31:0] NAME1   = 32'h746d7220,
  parameter logic [31:0] VERSION = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] ADDR_NAME0     = 8'h00;
  localparam logic [7:0] ADDR_NAME1     = 8'h01;
  localparam logic [7:0] ADDR_VERSION   = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_PRESCALER = 8'h0a;
  localparam logic [7:0] ADDR_TIMER     = 8'h0b;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state;
  logic              expired;
  logic [DATA_W-1:0] prescaler_reg;
  logic [DATA_W-1:0] timer_reg;
  logic [DATA_W-1:0] count_reg;
  logic [DATA_W-1:0] pre_ctr;

  logic              running;
  logic              wr;
  logic              start_req;
  logic              stop_req;
  logic [DATA_W-1:0] pe_m1;
  logic [DATA_W-1:0] rd_mux;

  assign running   = (state == ST_RUN);
  assign wr        = cs & we;
  // Stop takes priority when both control bits are written together.
  assign stop_req  = wr && (address == ADDR_CTRL) && write_data[1];
  assign start_req = wr && (address == ADDR_CTRL) && write_data[0] && !write_data[1];
  assign pe_m1     = (prescaler_reg == '0) ? '0 : prescaler_reg - DATA_W'(1);

  // Read mux; count_reg mirrors timer_reg until a start, so TIMER always reads count_reg.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_NAME0:     rd_mux = NAME0;
      ADDR_NAME1:     rd_mux = NAME1;
      ADDR_VERSION:   rd_mux = VERSION;
      ADDR_STATUS:    rd_mux = {30'd0, expired, running};
      ADDR_PRESCALER: rd_mux = prescaler_reg;
      ADDR_TIMER:     rd_mux = count_reg;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      expired       <= 1'b0;
      prescaler_reg <= '0;
      timer_reg     <= '0;
      count_reg     <= '0;
      pre_ctr       <= '0;
      ready         <= 1'b0;
      read_data     <= '0;
    end else begin
      ready     <= cs;
      read_data <= (cs && !we) ? rd_mux : '0;
      case (state)
        ST_IDLE: begin
          if (wr && address == ADDR_PRESCALER) prescaler_reg <= write_data;
          if (wr && address == ADDR_TIMER) begin
            timer_reg <= write_data;
            count_reg <= write_data;
          end
          if (start_req) begin
            count_reg <= timer_reg;
            pre_ctr   <= pe_m1;
            expired   <= (timer_reg == '0);
            if (timer_reg != '0) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop_req) begin
            state <= ST_IDLE;
          end else if (pre_ctr == '0) begin
            count_reg <= count_reg - DATA_W'(1);
            pre_ctr   <= pe_m1;
            if (count_reg == DATA_W'(1)) begin
              state   <= ST_IDLE;
              expired <= 1'b1;
            end
          end else begin
            pre_ctr <= pre_ctr - DATA_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsm_timer.sv
// Scoreboard bench for hsm_timer: directed scenarios plus random MMIO traffic,
// expected reads derived from an elapsed-time model of the countdown.
module tb_hsm_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  always #5 clk = ~clk;

  hsm_timer dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  addr;
    logic        we;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     failures = 0;
  longint edge_n = 0;

  // Reference state: when running, the count is a function of edges elapsed since start.
  bit          m_run;
  bit          m_exp;
  longint      m_t, m_base, m_pe;
  logic [31:0] m_count, m_timer, m_pre;

  task automatic model_reset();
    m_run = 0; m_exp = 0; m_t = 0; m_base = 0; m_pe = 1;
    m_count = '0; m_timer = '0; m_pre = '0;
  endtask

  function automatic longint cnt_after(longint x);
    longint d;
    d = (x - m_t) / m_pe;
    return (d >= m_base) ? 64'sd0 : m_base - d;
  endfunction

  task automatic model_access(input logic w, input logic [7:0] a, input logic [31:0] d);
    longint      e;
    logic [31:0] cur;
    exp_t        x;
    e = edge_n;
    if (m_run && cnt_after(e - 1) == 0) begin
      m_run = 0; m_count = '0; m_exp = 1;
    end
    cur = m_run ? 32'(cnt_after(e - 1)) : m_count;
    x.data = '0; x.addr = a; x.we = w;
    if (!w) begin
      case (a)
        8'h00: x.data = 32'h68736d5f;
        8'h01: x.data = 32'h746d7220;
        8'h02: x.data = 32'h00000001;
        8'h09: x.data = {30'd0, m_exp, m_run};
        8'h0a: x.data = m_pre;
        8'h0b: x.data = cur;
        default: x.data = '0;
      endcase
    end else begin
      if (a == 8'h0a && !m_run) m_pre = d;
      if (a == 8'h0b && !m_run) begin m_timer = d; m_count = d; end
      if (a == 8'h08) begin
        if (d[1]) begin
          if (m_run) begin m_count = cur; m_run = 0; end
        end else if (d[0] && !m_run) begin
          m_count = m_timer;
          if (m_timer == 0) m_exp = 1;
          else begin
            m_exp = 0; m_run = 1; m_t = e;
            m_base = longint'({32'd0, m_timer});
            m_pe = (m_pre == 0) ? 64'sd1 : longint'({32'd0, m_pre});
          end
        end
      end
    end
    sb_q.push_back(x);
  endtask

  // One bus cycle; entered and left just after a falling edge.
  task automatic bus(input logic c, input logic w, input logic [7:0] a, input logic [31:0] d);
    cs = c; we = w; address = a; write_data = d;
    @(posedge clk);
    edge_n++;
    if (c && !reset) model_access(w, a, d);
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a);
    bus(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  // Monitor: every acknowledged access pops one expectation; ready must not appear otherwise.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (reset) begin
      checks++;
      if (ready !== 1'b0 || read_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs ready=%b read_data=%h required ready=0 read_data=00000000",
                 ready, read_data);
      end
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      checks++;
      if (ready !== 1'b1 || read_data !== x.data) begin
        failures++;
        $display("FAIL access addr=%h we=%b got ready=%b read_data=%h required ready=1 read_data=%h t=%0t",
                 x.addr, x.we, ready, read_data, x.data, $time);
      end
    end else begin
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL spurious_ready got ready=%b required ready=0 t=%0t", ready, $time);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    logic [7:0]  a;
    logic [31:0] d;
    model_reset();
    reset = 1'b1; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // ID words, status, control and unmapped reads after reset
    rd(8'h00); rd(8'h01); rd(8'h02); rd(8'h09); rd(8'h08); rd(8'h05); rd(8'h0b); rd(8'h0a);
    idle(2);

    // Prescale 3, count 4
    wr(8'h0a, 32'd3); wr(8'h0b, 32'd4); rd(8'h0b); wr(8'h08, 32'd1);
    for (int i = 0; i < 14; i++) begin
      if (i % 3 == 2) rd(8'h09); else rd(8'h0b);
    end
    rd(8'h09); rd(8'h0a);

    // Prescale 0 behaves as 1
    wr(8'h0a, 32'd0); wr(8'h0b, 32'd5); wr(8'h08, 32'd1);
    for (int i = 0; i < 7; i++) rd(8'h0b);
    rd(8'h09);
    wr(8'h0a, 32'd1); wr(8'h08, 32'd1);
    for (int i = 0; i < 7; i++) rd(8'h0b);
    rd(8'h09);

    // Stop freezes the count; TIMER write while running is ignored
    wr(8'h0b, 32'd100); wr(8'h08, 32'd1); idle(9); wr(8'h08, 32'd2);
    rd(8'h0b); rd(8'h09); idle(3); rd(8'h0b);
    wr(8'h0b, 32'd7); rd(8'h0b); wr(8'h08, 32'd1); wr(8'h0b, 32'd50); wr(8'h0a, 32'd9);
    for (int i = 0; i < 9; i++) rd(8'h0b);
    rd(8'h09); rd(8'h0a);

    // Zero count expires immediately; CTRL=3 stops a running timer
    wr(8'h0b, 32'd0); wr(8'h08, 32'd1); rd(8'h09); rd(8'h0b);
    wr(8'h0b, 32'd30); wr(8'h08, 32'd1); idle(4); wr(8'h08, 32'd3); rd(8'h09); rd(8'h0b);
    wr(8'h08, 32'd3); rd(8'h09);

    // Asynchronous reset mid-count, with a read acknowledge pending
    wr(8'h0a, 32'd2); wr(8'h0b, 32'd1000); wr(8'h08, 32'd1); idle(20);
    cs = 1'b1; we = 1'b0; address = 8'h0b; write_data = '0;
    @(posedge clk);
    edge_n++;
    model_access(1'b0, 8'h0b, 32'd0);
    #2 reset = 1'b1;
    model_reset();
    cs = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rd(8'h0b); rd(8'h09); rd(8'h0a); idle(10); rd(8'h0b); rd(8'h09);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 7))
          0: a = 8'h00;
          1: a = 8'h02;
          2: a = 8'h08;
          3: a = 8'h09;
          4: a = 8'h0a;
          5, 6: a = 8'h0b;
          default: a = 8'($urandom_range(0, 255));
        endcase
        case (a)
          8'h08:   d = 32'($urandom_range(0, 3));
          8'h0a:   d = 32'($urandom_range(0, 3));
          8'h0b:   d = 32'($urandom_range(0, 12));
          default: d = $urandom;
        endcase
        bus(1'b1, 1'($urandom_range(0, 1)), a, d);
      end
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
